hsi_pixel_sequencer: RTL and testbench

Frame-level controller for the HSI vector core. It takes the configuration programmed through the core wrapper (op code, band count, pixel count) and issues one single-cycle start per pixel to the core. A start is issued only when both input FIFOs hold data and the output FIFO has room. It counts completed pixels, captures core errors, and reports frame completion and busy status back to the register interface.

---
 rtl/hsi_pixel_sequencer_if.sv | 31 +++
 rtl/hsi_pixel_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_hsi_pixel_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsi_pixel_sequencer_if.sv
// Core-side handshake of the HSI pixel sequencer.
// The master modport is the sequencer: it presents the latched op code and
// band count plus the per-pixel start strobe, and receives done/error back
// from the vector core (slave modport).
interface hsi_pixel_sequencer_if #(
  parameter int OP_CODE_WIDTH   = 4,
  parameter int NUM_BANDS_WIDTH = 32,
  parameter int ERR_WIDTH       = 4
);
  logic [OP_CODE_WIDTH-1:0]   core_op_code_o;
  logic [NUM_BANDS_WIDTH-1:0] core_num_bands_o;
  logic                       core_start_o;
  logic                       core_pixel_done_i;
  logic [ERR_WIDTH-1:0]       core_error_code_i;

  modport master (
    output core_op_code_o,
    output core_num_bands_o,
    output core_start_o,
    input  core_pixel_done_i,
    input  core_error_code_i
  );

  modport slave (
    input  core_op_code_o,
    input  core_num_bands_o,
    input  core_start_o,
    output core_pixel_done_i,
    output core_error_code_i
  );
endinterface

// File: rtl/hsi_pixel_sequencer.sv
// HSI pixel sequencer: frame-level controller for the HSI vector core.
// Latches the frame configuration, issues one single-cycle core start per
// pixel whenever both input FIFOs hold data and the output FIFO has room,
// counts completed pixels, captures core errors and reports frame status.
//
// Optional build macro HSI_SEQ_TIMEOUT_EN adds a per-pixel watchdog: if the
// core stays silent for TIMEOUT_CYCLES cycles in RUN, err_code_o is set to
// all-ones and the frame ends in ERROR. Without the macro RUN waits forever.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no frame; waits for frame_start_i to latch config
// WAIT_DATA | frame active; waits for both input FIFOs and output room
// START     | drives the one-cycle core start for the current pixel
// RUN       | waits for the core to report pixel done or an error
// DONE      | all pixels complete; frame_done_o pulses on the next cycle
// ERROR     | core error captured; frame ends without frame_done_o
module hsi_pixel_sequencer #(
  parameter int OP_CODE_WIDTH   = 4,
  parameter int NUM_BANDS_WIDTH = 32,
  parameter int PIX_CNT_WIDTH   = 16,
  parameter int ERR_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       frame_start_i,
  input  logic                       abort_i,
  input  logic [OP_CODE_WIDTH-1:0]   op_code_i,
  input  logic [NUM_BANDS_WIDTH-1:0] num_bands_i,
  input  logic [PIX_CNT_WIDTH-1:0]   num_pixels_i,
  input  logic                       in1_empty_i,
  input  logic                       in2_empty_i,
  input  logic                       out_full_i,
  hsi_pixel_sequencer_if.master      core_if,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic [ERR_WIDTH-1:0]       err_code_o,
  output logic [PIX_CNT_WIDTH-1:0]   pix_count_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_START     = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [OP_CODE_WIDTH-1:0]   r_op_code;
  logic [NUM_BANDS_WIDTH-1:0] r_num_bands;
  logic [PIX_CNT_WIDTH-1:0]   r_num_pixels;
  logic [PIX_CNT_WIDTH-1:0]   r_pix_count;
  logic [ERR_WIDTH-1:0]       r_err_code;
  logic                       r_frame_done;

  logic                       w_data_ready;
  logic                       w_core_err;
  logic [PIX_CNT_WIDTH-1:0]   w_pix_count_inc;
  logic                       w_last_pixel;
  logic                       w_timeout;
  logic                       w_accept;
  logic                       w_pix_inc;
  logic                       w_err_load;
  logic [ERR_WIDTH-1:0]       w_err_nxt;

  assign w_data_ready    = !in1_empty_i && !in2_empty_i && !out_full_i;
  assign w_core_err      = (core_if.core_error_code_i != '0);
  // num_pixels never exceeds 2^PIX_CNT_WIDTH-1, so this increment cannot wrap
  // before the terminal compare ends the frame.
  assign w_pix_count_inc = r_pix_count + 1'b1;
  assign w_last_pixel    = (w_pix_count_inc == r_num_pixels);

`ifdef HSI_SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;

  // Watchdog down-counter: held at the reload value outside RUN, so it starts
  // fresh on every entry to RUN and reaches zero on the last allowed cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wd_cnt <= '0;
    end else if (r_state != S_RUN) begin
      r_wd_cnt <= WD_LOAD;
    end else if (r_wd_cnt != '0) begin
      r_wd_cnt <= r_wd_cnt - 1'b1;
    end
  end

  assign w_timeout = (r_state == S_RUN) && (r_wd_cnt == '0);
`else
  // Watchdog compiled out: RUN waits for the core indefinitely. The limit is
  // still referenced so the parameter list stays identical across builds.
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout            = 1'b0;
`endif

  // Next-state and per-cycle control decode; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_pix_inc   = 1'b0;
    w_err_load  = 1'b0;
    w_err_nxt   = r_err_code;

    case (r_state)
      S_IDLE: begin
        if (frame_start_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (num_pixels_i == '0) ? S_DONE : S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (w_data_ready) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_core_err) begin
          // error wins over a simultaneous done; the pixel is not counted
          w_err_load  = 1'b1;
          w_err_nxt   = core_if.core_error_code_i;
          w_state_nxt = S_ERROR;
        end else if (core_if.core_pixel_done_i) begin
          w_pix_inc   = 1'b1;
          w_state_nxt = w_last_pixel ? S_DONE : S_WAIT_DATA;
        end else if (w_timeout) begin
          w_err_load  = 1'b1;
          w_err_nxt   = {ERR_WIDTH{1'b1}};
          w_state_nxt = S_ERROR;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_ERROR: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (abort_i) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
      w_pix_inc   = 1'b0;
      w_err_load  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame configuration: captured only on an accepted frame start, so the
  // core sees a stable op code and band count for the whole frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op_code    <= '0;
      r_num_bands  <= '0;
      r_num_pixels <= '0;
    end else if (w_accept) begin
      r_op_code    <= op_code_i;
      r_num_bands  <= num_bands_i;
      r_num_pixels <= num_pixels_i;
    end
  end

  // Completed-pixel counter; cleared on frame start, held through abort/error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pix_count <= '0;
    end else if (w_accept) begin
      r_pix_count <= '0;
    end else if (w_pix_inc) begin
      r_pix_count <= w_pix_count_inc;
    end
  end

  // Sticky error capture; only a new accepted frame clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_code <= '0;
    end else if (w_accept) begin
      r_err_code <= '0;
    end else if (w_err_load) begin
      r_err_code <= w_err_nxt;
    end
  end

  // Frame-done pulse issued the cycle after DONE, unless that DONE was aborted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == S_DONE) && !abort_i;
    end
  end

  assign core_if.core_op_code_o   = r_op_code;
  assign core_if.core_num_bands_o = r_num_bands;
  // START lasts exactly one cycle, so the strobe can never repeat back to back.
  assign core_if.core_start_o     = (r_state == S_START) && !abort_i;

  assign busy_o       = (r_state != S_IDLE);
  assign frame_done_o = r_frame_done;
  assign err_code_o   = r_err_code;
  assign pix_count_o  = r_pix_count;

endmodule

// File: tb/tb_hsi_pixel_sequencer.sv
// Self-checking bench for hsi_pixel_sequencer: directed scenarios followed by
// randomized frames checked against a frame-level outcome model.
module tb_hsi_pixel_sequencer;

  localparam int OPW = 4;
  localparam int NBW = 32;
  localparam int PCW = 16;
  localparam int ERW = 4;
  localparam int TMO = 16;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           frame_start_i = 1'b0;
  logic           abort_i = 1'b0;
  logic [OPW-1:0] op_code_i = '0;
  logic [NBW-1:0] num_bands_i = '0;
  logic [PCW-1:0] num_pixels_i = '0;
  logic           in1_empty_i;
  logic           in2_empty_i;
  logic           out_full_i;
  logic           busy_o;
  logic           frame_done_o;
  logic [ERW-1:0] err_code_o;
  logic [PCW-1:0] pix_count_o;

  // FIFO status: directed values or per-cycle random noise
  logic fifo_rand = 1'b0;
  logic dir_in1 = 1'b0, dir_in2 = 1'b0, dir_full = 1'b0;
  logic rnd_in1 = 1'b0, rnd_in2 = 1'b0, rnd_full = 1'b0;
  assign in1_empty_i = fifo_rand ? rnd_in1  : dir_in1;
  assign in2_empty_i = fifo_rand ? rnd_in2  : dir_in2;
  assign out_full_i  = fifo_rand ? rnd_full : dir_full;

  // core responder configuration
  logic           resp_en = 1'b1;
  int             resp_delay = 4;
  int             resp_err_pix = 0;
  logic [ERW-1:0] resp_err_code = '0;
  int             resp_idx = 0;

  // monitor statistics
  int   start_cnt = 0, done_cnt = 0, dbl_cnt = 0, viol_cnt = 0;
  logic prev_start = 1'b0, prev_ready = 1'b0;

  int n_cmp = 0, n_fail = 0;
  int s0, d0;
  int n_pix, e_pix, exp_starts, exp_pix, exp_done;
  logic [ERW-1:0] e_code, exp_err;
  logic [OPW-1:0] r_op;
  logic [NBW-1:0] r_bands;

  hsi_pixel_sequencer_if #(.OP_CODE_WIDTH(OPW), .NUM_BANDS_WIDTH(NBW), .ERR_WIDTH(ERW)) u_if ();

  hsi_pixel_sequencer #(
    .OP_CODE_WIDTH  (OPW),
    .NUM_BANDS_WIDTH(NBW),
    .PIX_CNT_WIDTH  (PCW),
    .ERR_WIDTH      (ERW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .frame_start_i(frame_start_i),
    .abort_i      (abort_i),
    .op_code_i    (op_code_i),
    .num_bands_i  (num_bands_i),
    .num_pixels_i (num_pixels_i),
    .in1_empty_i  (in1_empty_i),
    .in2_empty_i  (in2_empty_i),
    .out_full_i   (out_full_i),
    .core_if      (u_if),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .err_code_o   (err_code_o),
    .pix_count_o  (pix_count_o)
  );

  always #5 clk_i = ~clk_i;

  // random FIFO status, refreshed just after each rising edge
  initial begin
    forever begin
      @(posedge clk_i); #1;
      rnd_in1  = ($urandom_range(0, 3) == 0);
      rnd_in2  = ($urandom_range(0, 3) == 0);
      rnd_full = ($urandom_range(0, 3) == 0);
    end
  end

  // core model: answers each start with done (and optionally an error) after resp_delay cycles
  initial begin
    u_if.core_pixel_done_i = 1'b0;
    u_if.core_error_code_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (!busy_o) resp_idx = 0;
      if (u_if.core_start_o && resp_en) begin
        resp_idx = resp_idx + 1;
        repeat (resp_delay) @(posedge clk_i);
        #1;
        u_if.core_pixel_done_i = 1'b1;
        if (resp_idx == resp_err_pix) u_if.core_error_code_i = resp_err_code;
        @(posedge clk_i); #1;
        u_if.core_pixel_done_i = 1'b0;
        u_if.core_error_code_i = '0;
      end
    end
  end

  // protocol monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk_i);
      if (u_if.core_start_o) begin
        start_cnt = start_cnt + 1;
        if (prev_start) dbl_cnt = dbl_cnt + 1;
        if (!prev_ready) viol_cnt = viol_cnt + 1;
      end
      if (frame_done_o) done_cnt = done_cnt + 1;
      prev_start = u_if.core_start_o;
      prev_ready = !in1_empty_i && !in2_empty_i && !out_full_i;
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drives a one-cycle frame_start; returns in the cycle after the request
  task automatic start_frame(input logic [OPW-1:0] op, input logic [NBW-1:0] bands,
                             input logic [PCW-1:0] npix);
    op_code_i     = op;
    num_bands_i   = bands;
    num_pixels_i  = npix;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy_o && k < 1000) begin tick(); k++; end
    chk(tag, 64'(busy_o), 64'd0);
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (!u_if.core_start_o && k < 300) begin tick(); k++; end
    chk(tag, 64'(u_if.core_start_o), 64'd1);
  endtask

  task automatic wait_pix(input string tag, input int target);
    int k;
    k = 0;
    while (int'(pix_count_o) != target && k < 300) begin tick(); k++; end
    chk(tag, 64'(pix_count_o), 64'(target));
  endtask

  initial begin
    // ---- reset values ----
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    chk("rst_busy",       64'(busy_o), 64'd0);
    chk("rst_frame_done", 64'(frame_done_o), 64'd0);
    chk("rst_core_start", 64'(u_if.core_start_o), 64'd0);
    chk("rst_err",        64'(err_code_o), 64'd0);
    chk("rst_pix",        64'(pix_count_o), 64'd0);
    chk("rst_op",         64'(u_if.core_op_code_o), 64'd0);
    chk("rst_bands",      64'(u_if.core_num_bands_o), 64'd0);

    // ---- basic 3-pixel frame, core done 4 cycles after each start ----
    resp_en = 1'b1; resp_delay = 4; resp_err_pix = 0;
    s0 = start_cnt; d0 = done_cnt;
    start_frame(4'hA, 32'h1234_5678, 16'd3);
    chk("basic_busy_next",  64'(busy_o), 64'd1);
    chk("basic_no_start_1", 64'(u_if.core_start_o), 64'd0);
    tick();
    chk("basic_start_latency2", 64'(u_if.core_start_o), 64'd1);
    wait_idle("basic_idle_timeout");
    tick(); tick();
    chk("basic_starts",     64'(start_cnt - s0), 64'd3);
    chk("basic_pix",        64'(pix_count_o), 64'd3);
    chk("basic_frame_done", 64'(done_cnt - d0), 64'd1);
    chk("basic_op",         64'(u_if.core_op_code_o), 64'hA);
    chk("basic_bands",      64'(u_if.core_num_bands_o), 64'h1234_5678);

    // ---- FIFO backpressure ----
    dir_in1 = 1'b1;
    s0 = start_cnt; d0 = done_cnt;
    start_frame(4'h2, 32'd77, 16'd2);
    repeat (9) tick();
    chk("bp_in1_no_start",  64'(start_cnt - s0), 64'd0);
    chk("bp_in1_start_low", 64'(u_if.core_start_o), 64'd0);
    dir_in1 = 1'b0;
    tick();
    chk("bp_in1_release_start", 64'(u_if.core_start_o), 64'd1);
    dir_full = 1'b1;
    repeat (10) tick();
    chk("bp_full_pix",      64'(pix_count_o), 64'd1);
    chk("bp_full_no_start", 64'(start_cnt - s0), 64'd1);
    dir_full = 1'b0;
    tick();
    chk("bp_full_release_start", 64'(u_if.core_start_o), 64'd1);
    wait_idle("bp_idle_timeout");
    tick(); tick();
    chk("bp_pix",        64'(pix_count_o), 64'd2);
    chk("bp_frame_done", 64'(done_cnt - d0), 64'd1);

    // ---- core error with simultaneous done on pixel 2 ----
    resp_err_pix = 2; resp_err_code = 4'h5;
    s0 = start_cnt; d0 = done_cnt;
    start_frame(4'h5, 32'd10, 16'd5);
    wait_idle("err_idle_timeout");
    tick(); tick();
    chk("err_code",    64'(err_code_o), 64'h5);
    chk("err_pix",     64'(pix_count_o), 64'd1);
    chk("err_no_done", 64'(done_cnt - d0), 64'd0);
    chk("err_starts",  64'(start_cnt - s0), 64'd2);
    resp_err_pix = 0;

    // ---- zero-pixel frame: clears sticky error, done 2 cycles after start ----
    s0 = start_cnt; d0 = done_cnt;
    start_frame(4'h1, 32'd3, 16'd0);
    chk("zero_err_cleared", 64'(err_code_o), 64'd0);
    chk("zero_busy",        64'(busy_o), 64'd1);
    tick();
    chk("zero_done_pulse",  64'(frame_done_o), 64'd1);
    chk("zero_busy_clear",  64'(busy_o), 64'd0);
    tick(); tick();
    chk("zero_no_start",    64'(start_cnt - s0), 64'd0);
    chk("zero_one_done",    64'(done_cnt - d0), 64'd1);

    // ---- restart while busy ignored, then abort in RUN after 2 pixels ----
    d0 = done_cnt;
    start_frame(4'h3, 32'h0000_CAFE, 16'd3);
    tick();
    op_code_i = 4'h7; num_bands_i = 32'h1111; num_pixels_i = 16'd9;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    chk("busy_restart_op",    64'(u_if.core_op_code_o), 64'h3);
    chk("busy_restart_bands", 64'(u_if.core_num_bands_o), 64'hCAFE);
    wait_pix("abort_reach_two", 2);
    wait_start("abort_third_start");
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy",  64'(busy_o), 64'd0);
    chk("abort_pix",   64'(pix_count_o), 64'd2);
    repeat (6) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_still_idle", 64'(busy_o), 64'd0);

    // ---- reset mid-frame ----
    start_frame(4'h9, 32'h0000_BEEF, 16'd4);
    wait_pix("rst_mid_reach_one", 1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rstmid_busy",  64'(busy_o), 64'd0);
    chk("rstmid_pulses", 64'({frame_done_o, u_if.core_start_o}), 64'd0);
    chk("rstmid_pix",   64'(pix_count_o), 64'd0);
    chk("rstmid_err",   64'(err_code_o), 64'd0);
    chk("rstmid_cfg",   64'({u_if.core_op_code_o, u_if.core_num_bands_o}), 64'd0);
    repeat (8) tick();

    // ---- randomized frames against the frame-outcome model ----
    fifo_rand = 1'b1;
    for (int f = 0; f < 10; f++) begin
      n_pix      = int'($urandom_range(1, 6));
      r_op       = OPW'($urandom_range(0, 15));
      r_bands    = $urandom;
      resp_delay = int'($urandom_range(1, 5));
      e_pix      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n_pix)) : 0;
      e_code     = ERW'($urandom_range(1, 15));
      resp_err_pix  = e_pix;
      resp_err_code = e_code;
      // expected outcome: an error on pixel k ends the frame after k starts
      // with k-1 pixels counted; otherwise every pixel completes
      exp_starts = (e_pix != 0) ? e_pix : n_pix;
      exp_pix    = (e_pix != 0) ? e_pix - 1 : n_pix;
      exp_err    = (e_pix != 0) ? e_code : '0;
      exp_done   = (e_pix != 0) ? 0 : 1;
      s0 = start_cnt; d0 = done_cnt;
      start_frame(r_op, r_bands, PCW'(n_pix));
      wait_idle("rand_idle_timeout");
      tick(); tick();
      chk("rand_starts", 64'(start_cnt - s0), 64'(exp_starts));
      chk("rand_pix",    64'(pix_count_o), 64'(exp_pix));
      chk("rand_err",    64'(err_code_o), 64'(exp_err));
      chk("rand_done",   64'(done_cnt - d0), 64'(exp_done));
      chk("rand_op",     64'(u_if.core_op_code_o), 64'(r_op));
      chk("rand_bands",  64'(u_if.core_num_bands_o), 64'(r_bands));
    end
    fifo_rand = 1'b0;
    resp_err_pix = 0;
    repeat (4) tick();

`ifdef HSI_SEQ_TIMEOUT_EN
    // ---- watchdog: silent core times out 16 cycles after entering RUN ----
    resp_en = 1'b0;
    start_frame(4'h4, 32'd5, 16'd1);
    wait_start("tmo_start");
    repeat (16) tick();
    chk("tmo_not_yet", 64'(err_code_o), 64'd0);
    tick();
    chk("tmo_err_ones", 64'(err_code_o), 64'hF);
    wait_idle("tmo_idle_timeout");
    resp_en = 1'b1;
`endif

    chk("no_back_to_back_start", 64'(dbl_cnt), 64'd0);
    chk("start_only_when_ready", 64'(viol_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
